// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory stage: op codes, FSM states, load lane formatting.
package cpu_mem_pkg;

    localparam int unsigned OP_W = 6;

    // ALU pass-through range and link ops
    localparam logic [OP_W-1:0] OP_ALU_LO = 6'b000000;
    localparam logic [OP_W-1:0] OP_ALU_HI = 6'b000101;
    localparam logic [OP_W-1:0] OP_LINK0  = 6'b100000;
    localparam logic [OP_W-1:0] OP_LINK1  = 6'b100001;

    // Load/store ops
    localparam logic [OP_W-1:0] OP_SW  = 6'b010000;
    localparam logic [OP_W-1:0] OP_LW  = 6'b010001;
    localparam logic [OP_W-1:0] OP_SH  = 6'b010010;
    localparam logic [OP_W-1:0] OP_LH  = 6'b010011;
    localparam logic [OP_W-1:0] OP_SB  = 6'b010100;
    localparam logic [OP_W-1:0] OP_LB  = 6'b010101;
    localparam logic [OP_W-1:0] OP_LHU = 6'b010110;
    localparam logic [OP_W-1:0] OP_LBU = 6'b010111;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return op[5:3] == 3'b010;
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Misalignment only; range is checked separately since it depends on DEPTH
    function automatic logic align_err(input logic [OP_W-1:0] op, input logic [1:0] lane);
        logic err;
        err = 1'b0;
        case (op)
            OP_SW, OP_LW:          err = (lane != 2'b00);
            OP_SH, OP_LH, OP_LHU:  err = lane[0];
            default:               err = 1'b0;
        endcase
        return err;
    endfunction

    // Pick the addressed little-endian lane(s) and extend to 32 bits
    function automatic logic [31:0] load_format(input logic [OP_W-1:0] op,
                                                input logic [31:0] word,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM with byte-enable write and registered read.
// Ports: clk, we (write strobe), be (lane enables), addr (word index),
//        wdata (write word), rdata (word read, valid the cycle after addr).
module dmem_ram #(
    parameter int unsigned DEPTH     = 256,
    parameter string       INIT_FILE = "data.txt"
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: request latch, sequencing FSM with wait states, alignment/range
// check, load formatter and writeback mux in front of dmem_ram.
// Ports: clk, rst_n (sync, active-low), start_i (request, sampled in IDLE),
//        op_i/alu_i/addr_i (operation, ALU result or store data, byte address),
//        write_o (writeback value), done_o (completion pulse), busy_o, err_o.
module mem_stage_ctrl #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned WAIT_CYC  = 1,
    parameter string       INIT_FILE = "data.txt"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] addr_i,
    output logic [31:0] write_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        err_o
);
    import cpu_mem_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    state_t          state;
    logic [5:0]      op_q;
    logic [31:0]     alu_q;
    logic [AW-1:0]   idx_q;
    logic [1:0]      lane_q;
    logic [3:0]      cnt;

    logic            req_err_c;
    logic            enter_done_c;
    logic            we_c;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c;
    logic [AW-1:0]   ram_addr_c;
    logic [31:0]     rdata;

    // Request-time error: misaligned or above the RAM window
    assign req_err_c = is_mem_op(op_i) &&
                       (align_err(op_i, addr_i[1:0]) || (addr_i[31:AW+2] != '0));

    // Present the incoming index in IDLE so read data is ready by the end of ACCESS
    assign ram_addr_c = (state == IDLE) ? addr_i[AW+1:2] : idx_q;

    // Edge on which the FSM enters DONE from a memory access
    always_comb begin
        enter_done_c = 1'b0;
        case (state)
            ACCESS:  enter_done_c = (WAIT_CYC == 0);
            WAIT:    enter_done_c = (cnt == 4'd1);
            default: enter_done_c = 1'b0;
        endcase
    end

    // Store lane steering; commit only on DONE entry and never under reset
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = alu_q;
        case (op_q)
            OP_SW: be_c = 4'b1111;
            OP_SH: begin
                be_c    = lane_q[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{alu_q[15:0]}};
            end
            OP_SB: begin
                be_c    = 4'b0001 << lane_q;
                wdata_c = {4{alu_q[7:0]}};
            end
            default: be_c = 4'b0000;
        endcase
    end

    assign we_c = rst_n && enter_done_c && is_store(op_q);

    dmem_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .be    (be_c),
        .addr  (ram_addr_c),
        .wdata (wdata_c),
        .rdata (rdata)
    );

    // Sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            write_o <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
            err_o   <= 1'b0;
            op_q    <= '0;
            alu_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            cnt     <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        op_q   <= op_i;
                        alu_q  <= alu_i;
                        idx_q  <= addr_i[AW+1:2];
                        lane_q <= addr_i[1:0];
                        if (is_mem_op(op_i) && !req_err_c) begin
                            state <= ACCESS;
                        end else begin
                            // Non-memory and faulting ops finish immediately
                            state  <= DONE;
                            done_o <= 1'b1;
                            err_o  <= req_err_c;
                            if (op_i <= OP_ALU_HI) begin
                                write_o <= alu_i;
                            end else if ((op_i == OP_LINK0) || (op_i == OP_LINK1)) begin
                                write_o <= addr_i;
                            end
                        end
                    end
                end
                ACCESS: begin
                    cnt <= 4'(WAIT_CYC);
                    if (!enter_done_c) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (enter_done_c) begin
                state  <= DONE;
                done_o <= 1'b1;
                if (!is_store(op_q)) begin
                    write_o <= load_format(op_q, rdata, lane_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (DEPTH=256, WAIT_CYC=1, no preload).
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [5:0]  op_i;
    logic [31:0] alu_i;
    logic [31:0] addr_i;
    logic [31:0] write_o;
    logic        done_o;
    logic        busy_o;
    logic        err_o;

    int checks;
    int failures;

    mem_stage_ctrl #(
        .DEPTH     (256),
        .WAIT_CYC  (1),
        .INIT_FILE ("")
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .alu_i   (alu_i),
        .addr_i  (addr_i),
        .write_o (write_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE; lat = cycles from start to done_o (99 if it never came)
    task automatic run_op(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] addr,
                          output int lat, output logic err);
        op_i    = op;
        alu_i   = alu;
        addr_i  = addr;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 99;
        err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (done_o) begin
                lat = k;
                err = err_o;
                break;
            end
            tick();
        end
        tick();
    endtask

    int   lat;
    logic err;
    int   ndone;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        op_i     = '0;
        alu_i    = '0;
        addr_i   = '0;
        tick();
        tick();
        check("rst_write", write_o, 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // ALU pass-through
        run_op(6'b000011, 32'h1234, 32'h0, lat, err);
        check("alu_lat", 32'(lat), 32'd1);
        check("alu_write", write_o, 32'h1234);
        check("alu_err", 32'(err), 32'h0);
        check("alu_idle_busy", 32'(busy_o), 32'h0);

        // Word store/load
        run_op(6'b010000, 32'hDEADBEEF, 32'h10, lat, err);
        check("sw_lat", 32'(lat), 32'd3);
        check("sw_err", 32'(err), 32'h0);
        run_op(6'b010001, 32'h0, 32'h10, lat, err);
        check("lw_lat", 32'(lat), 32'd3);
        check("lw_data", write_o, 32'hDEADBEEF);

        // Sub-word
        run_op(6'b010100, 32'h80, 32'h13, lat, err);
        check("sb_lat", 32'(lat), 32'd3);
        run_op(6'b010001, 32'h0, 32'h10, lat, err);
        check("lw_after_sb", write_o, 32'h80ADBEEF);
        run_op(6'b010101, 32'h0, 32'h13, lat, err);
        check("lb", write_o, 32'hFFFFFF80);
        run_op(6'b010111, 32'h0, 32'h13, lat, err);
        check("lbu", write_o, 32'h00000080);
        run_op(6'b010011, 32'h0, 32'h12, lat, err);
        check("lh", write_o, 32'hFFFF80AD);
        run_op(6'b010110, 32'h0, 32'h12, lat, err);
        check("lhu", write_o, 32'h000080AD);

        // Errors: done next cycle with err_o, writeback held, no RAM write
        run_op(6'b010001, 32'h0, 32'h02, lat, err);
        check("lw_mis_lat", 32'(lat), 32'd1);
        check("lw_mis_err", 32'(err), 32'h1);
        check("lw_mis_hold", write_o, 32'h000080AD);
        run_op(6'b010010, 32'hFFFF, 32'h11, lat, err);
        check("sh_mis_err", 32'(err), 32'h1);
        check("sh_mis_hold", write_o, 32'h000080AD);
        run_op(6'b010001, 32'h0, 32'h400, lat, err);
        check("lw_range_err", 32'(err), 32'h1);
        check("lw_range_lat", 32'(lat), 32'd1);
        run_op(6'b010001, 32'h0, 32'h10, lat, err);
        check("ram_after_err", write_o, 32'h80ADBEEF);
        check("ram_after_err_e", 32'(err), 32'h0);

        // Start held high through ACCESS/WAIT/DONE must not queue a second op
        op_i    = 6'b010001;
        alu_i   = 32'h0;
        addr_i  = 32'h10;
        start_i = 1'b1;
        tick();
        op_i   = 6'b000000;
        alu_i  = 32'h77;
        addr_i = 32'h0;
        ndone  = 0;
        for (int k = 0; k < 8; k++) begin
            if (done_o) ndone++;
            if (k == 3) start_i = 1'b0;
            tick();
        end
        check("busy_ndone", 32'(ndone), 32'd1);
        check("busy_write", write_o, 32'h80ADBEEF);
        check("busy_end", 32'(busy_o), 32'h0);

        // Reset during WAIT aborts the store
        op_i    = 6'b010000;
        alu_i   = 32'h11111111;
        addr_i  = 32'h10;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("abort_in_wait", 32'(busy_o), 32'h1);
        rst_n = 1'b0;
        tick();
        check("abort_done", 32'(done_o), 32'h0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            if (done_o) ndone++;
            tick();
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op(6'b010001, 32'h0, 32'h10, lat, err);
        check("abort_old_data", write_o, 32'h80ADBEEF);

        // Link and undefined op
        run_op(6'b100001, 32'h0, 32'h40, lat, err);
        check("link_write", write_o, 32'h40);
        check("link_lat", 32'(lat), 32'd1);
        run_op(6'b111111, 32'h99, 32'h88, lat, err);
        check("nop_lat", 32'(lat), 32'd1);
        check("nop_hold", write_o, 32'h40);
        check("nop_err", 32'(err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
